// File: rtl/flow_pkg.sv
// Shared sizing helpers for the multi-channel buffer: clog2 plus channel-index,
// pointer and occupancy-count width derivations.
package flow_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int chan_width(input int nchan);
        return (nchan > 1) ? clog2(nchan) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, hence one bit more than a pointer.
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffer_mc_chan.sv
// Bookkeeping for one channel of buffer_mc: read/write pointers, occupancy count,
// and the accept/error decisions for write, delete and flush requests.
module buffer_mc_chan
    import flow_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = ptr_width(DEPTH),
    parameter int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req_i,
    input  logic             del_req_i,
    input  logic             flush_i,
    output logic             wr_accept_o,
    output logic             wr_error_o,
    output logic             del_error_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, del_accept;

    // Full/empty are judged on the pre-edge count, so a write into a full
    // channel is refused even when a delete frees a slot in the same cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        wr_accept_o = wr_req_i && !full && !flush_i;
        wr_error_o  = wr_req_i && full && !flush_i;
        del_accept  = del_req_i && !empty && !flush_i;
        del_error_o = del_req_i && empty && !flush_i;
        rd_ptr_d    = rd_ptr_q + PTR_W'(del_accept);
        wr_ptr_d    = wr_ptr_q + PTR_W'(wr_accept_o);
        count_d     = count_q + CNT_W'(wr_accept_o) - CNT_W'(del_accept);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/buffer_mc.sv
// Multi-channel first-word-fall-through buffer over one shared storage array with
// lookahead read outputs. Optional per-channel flush: define BUFFER_MC_FLUSH_EN.
module buffer_mc
    import flow_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 16,
    parameter  int NCHAN  = 4,
    localparam int CHAN_W = chan_width(NCHAN),
    localparam int CNT_W  = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_strobe,
    input  logic [CHAN_W-1:0] write_channel,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [CHAN_W-1:0] read_channel,
    input  logic              read_delete,
    output logic              read_full,
    output logic [WIDTH-1:0]  read_data,
    output logic [CNT_W-1:0]  read_count,
    output logic              error
`ifdef BUFFER_MC_FLUSH_EN
    ,
    input  logic              flush_strobe,
    input  logic [CHAN_W-1:0] flush_channel
`endif
);

    localparam int PTR_W     = ptr_width(DEPTH);
    localparam int MEM_WORDS = NCHAN * DEPTH;

    logic [WIDTH-1:0]  mem_q [MEM_WORDS];
    logic [PTR_W-1:0]  rd_ptr [NCHAN];
    logic [PTR_W-1:0]  wr_ptr [NCHAN];
    logic [CNT_W-1:0]  count  [NCHAN];
    logic [NCHAN-1:0]  wr_accept, wr_err, del_err;
    logic              wc_valid, rc_valid;
    logic              flush_req;
    logic [CHAN_W-1:0] flush_sel;
    logic [CNT_W-1:0]  rd_cnt;
    logic [PTR_W-1:0]  rd_ptr_sel;
    logic              write_err_q, write_err_d;
    logic              read_err_q, read_err_d;

`ifdef BUFFER_MC_FLUSH_EN
    assign flush_req = flush_strobe;
    assign flush_sel = flush_channel;
`else
    assign flush_req = 1'b0;
    assign flush_sel = '0;
`endif

    // Channel indices only need a range check when NCHAN is not a power of two.
    if (NCHAN == (1 << CHAN_W)) begin : g_full_range
        assign wc_valid = 1'b1;
        assign rc_valid = 1'b1;
    end else begin : g_part_range
        assign wc_valid = {1'b0, write_channel} < (CHAN_W + 1)'(NCHAN);
        assign rc_valid = {1'b0, read_channel} < (CHAN_W + 1)'(NCHAN);
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        buffer_mc_chan #(
            .DEPTH (DEPTH),
            .PTR_W (PTR_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_req_i    (write_strobe && wc_valid && (write_channel == CHAN_W'(c))),
            .del_req_i   (read_delete && rc_valid && (read_channel == CHAN_W'(c))),
            .flush_i     (flush_req && (flush_sel == CHAN_W'(c))),
            .wr_accept_o (wr_accept[c]),
            .wr_error_o  (wr_err[c]),
            .del_error_o (del_err[c]),
            .rd_ptr_o    (rd_ptr[c]),
            .wr_ptr_o    (wr_ptr[c]),
            .count_o     (count[c])
        );
    end

    // Physical address c*DEPTH + ptr is a plain concatenation since DEPTH is 2^PTR_W.
    always_ff @(posedge clk) begin
        if (|wr_accept) begin
            mem_q[{write_channel, wr_ptr[write_channel]}] <= write_data;
        end
    end

    // On delete the view advances one slot so the consumer sees the next word now.
    always_comb begin
        rd_cnt     = '0;
        rd_ptr_sel = '0;
        read_full  = 1'b0;
        if (rc_valid) begin
            rd_cnt     = count[read_channel];
            rd_ptr_sel = rd_ptr[read_channel] + PTR_W'(read_delete);
            read_full  = read_delete ? (rd_cnt >= CNT_W'(2)) : (rd_cnt != '0);
        end
        read_data  = mem_q[{read_channel, rd_ptr_sel}];
        read_count = rd_cnt;
    end

    always_comb begin
        write_err_d = write_err_q | (write_strobe && !wc_valid) | (|wr_err);
        read_err_d  = read_err_q | (read_delete && !rc_valid) | (|del_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_err_q <= 1'b0;
            read_err_q  <= 1'b0;
        end else begin
            write_err_q <= write_err_d;
            read_err_q  <= read_err_d;
        end
    end

    assign error = write_err_q | read_err_q;

endmodule

// File: tb/tb_buffer_mc.sv
// Bench for buffer_mc: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against per-channel queue model.
module tb_buffer_mc;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int NCHAN  = 4;
    localparam int CHAN_W = 2;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_strobe = 1'b0;
    logic [CHAN_W-1:0] write_channel = '0;
    logic [WIDTH-1:0]  write_data = '0;
    logic [CHAN_W-1:0] read_channel = '0;
    logic              read_delete = 1'b0;
    logic              read_full;
    logic [WIDTH-1:0]  read_data;
    logic [CNT_W-1:0]  read_count;
    logic              error;
    logic              flush_strobe = 1'b0;
    logic [CHAN_W-1:0] flush_channel = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    buffer_mc #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NCHAN (NCHAN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_strobe  (write_strobe),
        .write_channel (write_channel),
        .write_data    (write_data),
        .read_channel  (read_channel),
        .read_delete   (read_delete),
        .read_full     (read_full),
        .read_data     (read_data),
        .read_count    (read_count),
        .error         (error)
`ifdef BUFFER_MC_FLUSH_EN
        ,
        .flush_strobe  (flush_strobe),
        .flush_channel (flush_channel)
`endif
    );

    // ---------------- scoreboard / model ----------------
    int               errors = 0;
    int               checks = 0;
    bit               chk_en = 1'b0;
    logic [WIDTH-1:0] mq [NCHAN][$];
    bit               merr = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCHAN; c++) mq[c].delete();
        merr = 1'b0;
    endtask

    // Model advances on each active edge from the inputs held during the cycle.
    always @(posedge clk) begin
        int  wc, rc, fc;
        bit  wacc, dacc, fl;
        if (rst) begin
            model_clear();
        end else begin
            wc = int'(write_channel);
            rc = int'(read_channel);
            fl = 1'b0;
            fc = 0;
`ifdef BUFFER_MC_FLUSH_EN
            fl = flush_strobe;
            fc = int'(flush_channel);
`endif
            wacc = 1'b0;
            dacc = 1'b0;
            if (write_strobe) begin
                if (wc >= NCHAN) merr = 1'b1;
                else if (fl && fc == wc) wacc = 1'b0;
                else if (mq[wc].size() < DEPTH) wacc = 1'b1;
                else merr = 1'b1;
            end
            if (read_delete) begin
                if (rc >= NCHAN) merr = 1'b1;
                else if (fl && fc == rc) dacc = 1'b0;
                else if (mq[rc].size() > 0) dacc = 1'b1;
                else merr = 1'b1;
            end
            if (dacc) void'(mq[rc].pop_front());
            if (wacc) mq[wc].push_back(write_data);
            if (fl && fc < NCHAN) mq[fc].delete();
        end
    end

    always @(negedge clk) begin
        int c, n;
        bit ef;
        if (chk_en) begin
            c  = int'(read_channel);
            n  = (c < NCHAN) ? mq[c].size() : 0;
            ef = read_delete ? (n >= 2) : (n != 0);
            check("cmp.count", WIDTH'(read_count), WIDTH'(n));
            check("cmp.full", WIDTH'(read_full), WIDTH'(ef));
            if (ef) check("cmp.data", read_data, read_delete ? mq[c][1] : mq[c][0]);
            check("cmp.error", WIDTH'(error), WIDTH'(merr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        write_strobe = 1'b0;
        read_delete  = 1'b0;
        flush_strobe = 1'b0;
    endtask

    task automatic cycle(input bit ws, input int wc, input logic [WIDTH-1:0] wd, input int rc, input bit rd);
        write_strobe  = ws;
        write_channel = CHAN_W'(wc);
        write_data    = wd;
        read_channel  = CHAN_W'(rc);
        read_delete   = rd;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic peek(input string name, input int rc, input bit rd, input bit exp_full,
                        input logic [WIDTH-1:0] exp_data, input int exp_cnt);
        read_channel = CHAN_W'(rc);
        read_delete  = rd;
        #1;
        check({name, ".full"}, WIDTH'(read_full), WIDTH'(exp_full));
        if (exp_full) check({name, ".data"}, read_data, exp_data);
        check({name, ".count"}, WIDTH'(read_count), WIDTH'(exp_cnt));
        read_delete = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] first_word;
        logic [WIDTH-1:0] wd;
        int               wprob, wc, rc;
        bit               ws, rd;

        chk_en = 1'b1;
        do_reset();

        // reset state and a 5-word write to channel 2
        for (int c = 0; c < NCHAN; c++) peek("rst", c, 1'b0, 1'b0, '0, 0);
        check("rst.error", WIDTH'(error), '0);
        first_word = $urandom;
        cycle(1'b1, 2, first_word, 0, 1'b0);
        for (int i = 1; i < 5; i++) cycle(1'b1, 2, $urandom, 0, 1'b0);
        peek("ch2_5", 2, 1'b0, 1'b1, first_word, 5);
        peek("ch0_0", 0, 1'b0, 1'b0, '0, 0);
        peek("ch1_0", 1, 1'b0, 1'b0, '0, 0);
        peek("ch3_0", 3, 1'b0, 1'b0, '0, 0);

        // fill channel 1, overflow, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1, 32'h100 + i, 0, 1'b0);
        check("fill.noerr", WIDTH'(error), '0);
        cycle(1'b1, 1, 32'h1FF, 0, 1'b0);
        check("fill.overflow_err", WIDTH'(error), 1);
        for (int i = 0; i < DEPTH; i++) begin
            peek("drain", 1, 1'b0, 1'b1, 32'h100 + i, DEPTH - i);
            cycle(1'b0, 0, '0, 1, 1'b1);
        end
        peek("drain.empty", 1, 1'b0, 1'b0, '0, 0);

        // lookahead on delete
        do_reset();
        cycle(1'b1, 0, 32'hAAAA0001, 0, 1'b0);
        cycle(1'b1, 0, 32'hBBBB0002, 0, 1'b0);
        peek("la.two", 0, 1'b1, 1'b1, 32'hBBBB0002, 2);
        cycle(1'b0, 0, '0, 0, 1'b1);
        peek("la.one", 0, 1'b1, 1'b0, '0, 1);
        peek("la.head", 0, 1'b0, 1'b1, 32'hBBBB0002, 1);

        // back-to-back deletes on ch3 while writing ch0
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 3, 32'h300 + i, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            peek("b2b.ch3", 3, 1'b0, 1'b1, 32'h300 + i, 8 - i);
            cycle(1'b1, 0, 32'h500 + i, 3, 1'b1);
        end
        peek("b2b.ch0", 0, 1'b0, 1'b1, 32'h500, 8);
        peek("b2b.ch3_empty", 3, 1'b0, 1'b0, '0, 0);

        // write+delete at count 1 for 40 cycles; pointers wrap
        do_reset();
        cycle(1'b1, 1, 32'h700, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            peek("wd.la", 1, 1'b1, 1'b0, '0, 1);
            cycle(1'b1, 1, 32'h701 + i, 1, 1'b1);
            peek("wd.head", 1, 1'b0, 1'b1, 32'h701 + i, 1);
        end
        check("wd.noerr", WIDTH'(error), '0);

        // delete from empty, then asynchronous reset mid-stream
        do_reset();
        cycle(1'b0, 0, '0, 0, 1'b1);
        check("underflow.err", WIDTH'(error), 1);
        peek("underflow.ch0", 0, 1'b0, 1'b0, '0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1, 32'h900 + i, 0, 1'b0);
        peek("pre_arst.ch1", 1, 1'b0, 1'b1, 32'h900, 3);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        check("arst.error", WIDTH'(error), '0);
        for (int c = 0; c < NCHAN; c++) peek("arst", c, 1'b0, 1'b0, '0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef BUFFER_MC_FLUSH_EN
        // flush beats a same-cycle write on the same channel
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 2, 32'hF00 + i, 0, 1'b0);
        cycle(1'b1, 1, 32'hE00, 0, 1'b0);
        peek("flush.pre", 2, 1'b0, 1'b1, 32'hF00, 7);
        flush_strobe  = 1'b1;
        flush_channel = 2'd2;
        cycle(1'b1, 2, 32'hDEAD, 2, 1'b0);
        peek("flush.ch2", 2, 1'b0, 1'b0, '0, 0);
        peek("flush.ch1", 1, 1'b0, 1'b1, 32'hE00, 1);
        check("flush.noerr", WIDTH'(error), '0);
`endif

        // randomized traffic, alternating write-heavy and delete-heavy phases
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wprob = ((i / 500) % 2 == 0) ? 70 : 30;
            ws    = ($urandom_range(99) < wprob);
            rd    = ($urandom_range(99) < (100 - wprob));
            wc    = ($urandom_range(1) == 0) ? $urandom_range(1) : $urandom_range(NCHAN - 1);
            rc    = ($urandom_range(1) == 0) ? $urandom_range(1) : $urandom_range(NCHAN - 1);
            wd    = $urandom;
`ifdef BUFFER_MC_FLUSH_EN
            if ($urandom_range(49) == 0) begin
                flush_strobe  = 1'b1;
                flush_channel = CHAN_W'($urandom_range(NCHAN - 1));
            end
`endif
            if ($urandom_range(399) == 0) do_reset();
            else cycle(ws, wc, wd, rc, rd);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
